lake_config_sequencer: RTL
==========================

// Module: lake_config_sequencer
// PURPOSE
//  Loads the wide static configuration of one lakespec memory from a narrow word stream.
//  Commits the configuration atomically, then sequences the flush pulse that starts the schedule.
//  Sits between the CGRA config bus and lakespec.config_memory/flush.
//  Replaces the bench-side $readmemh load and the hand-timed flush.
// PARAMETERS
//  CONFIG_MEMORY_SIZE  512  width of lakespec config_memory, in bits
//  WORD_W              32   width of one incoming config word
//  FLUSH_CYCLES        4    cycles flush is held high after commit; must be >=1
//  NUM_WORDS           ceil(CONFIG_MEMORY_SIZE/WORD_W)  derived localparam, not overridable
// PORTS
//  clk             in   1                   clock
//  rst_n           in   1                   asynchronous active-low reset
//  cfg_start       in   1                   pulse: begin a new load
//  cfg_abort       in   1                   pulse: discard the load in progress
//  cfg_word_valid  in   1                   incoming word valid
//  cfg_word_ready  out  1                   sequencer accepts a word this cycle
//  cfg_word_data   in   WORD_W              config word; word k maps to bits [k*WORD_W +: WORD_W]
//  config_memory   out  CONFIG_MEMORY_SIZE  committed config, drives lakespec.config_memory
//  flush           out  1                   drives lakespec.flush
//  busy            out  1                   high in LOAD or FLUSH
//  done            out  1                   high in RUN: config committed and flush released
//  word_count      out  $clog2(NUM_WORDS+1) words accepted in the current load
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - state=IDLE; config_memory, shadow and word_count = 0.
//   - flush, busy, done and cfg_word_ready = 0.
//  States and transitions:
//   - IDLE --cfg_start--> LOAD.
//   - LOAD --last handshake--> FLUSH.
//   - FLUSH --count expired--> RUN.
//   - RUN --cfg_start--> LOAD.
//  cfg_start in IDLE or RUN:
//   - next state LOAD; shadow and word_count cleared.
//   - done drops with the state change.
//   - config_memory is held; the datapath keeps running the old config.
//  LOAD:
//   - cfg_word_ready=1 combinationally from the state; it is 0 in every other state.
//   - Handshake is valid&&ready; on each handshake word k is written into shadow slot k.
//   - Bits of the final word at or above CONFIG_MEMORY_SIZE are dropped.
//   - Valid low stalls indefinitely; there is no timeout.
//  Commit, at the edge of handshake NUM_WORDS-1:
//   - config_memory <= shadow merged with the current word; flush <= 1; state <= FLUSH.
//   - Commit latency is 0 extra cycles; config_memory and flush change on the same edge.
//  FLUSH:
//   - flush stays high for exactly FLUSH_CYCLES cycles.
//   - Then flush <= 0 and state <= RUN; done <= 1 on that edge.
//  cfg_start during LOAD or FLUSH: ignored.
//  cfg_abort:
//   - In LOAD: return to IDLE, shadow discarded, config_memory unchanged.
//   - In FLUSH: flush completes anyway (no abort), so the datapath is never left half-flushed.
//   - In IDLE or RUN: no effect.
//  Simultaneous cfg_abort and last handshake in LOAD: abort wins, no commit, config_memory unchanged.
//  Simultaneous cfg_start and cfg_abort: abort wins if in LOAD; otherwise start is taken.
//  Reset mid-LOAD or mid-FLUSH:
//   - Immediate return to reset values, including config_memory=0 and flush=0.
//  word_count:
//   - Saturates at NUM_WORDS and never wraps.
//   - Holds its final value in FLUSH and RUN; cleared on cfg_start.
// STRUCTURE
//  Package lake_cfg_pkg:
//   - typedef enum logic [1:0] {CFG_IDLE, CFG_LOAD, CFG_FLUSH, CFG_RUN} cfg_state_t.
//   - function num_words(size, w) returning the ceiling division.
//  Sub-module lake_flush_timer:
//   - load/count-down timer; inputs start, load value FLUSH_CYCLES; output active.
//   - Drives flush directly from its register, so flush is glitch-free.
//  Shadow register write: indexed part-select on word_count; no barrel shifter.
// TESTING
//  Bench parameters: CONFIG_MEMORY_SIZE=64, WORD_W=32, FLUSH_CYCLES=4.
//  1. Basic load: reset, start, valid words 0x11111111 then 0x22222222 back-to-back
//     -> config_memory=0x2222222211111111 at the 2nd handshake edge; flush high 4 cycles; then done=1.
//  2. Stalled load: valid low 10 cycles between words
//     -> cfg_word_ready held at 1; word_count=1 throughout the stall; result same as scenario 1.
//  3. Abort: abort after word 1 of a reload over committed 0xA5A5A5A5_5A5A5A5A
//     -> IDLE, config_memory unchanged, flush never asserts.
//  4. Ignored start and final-word truncation: start pulsed during FLUSH -> ignored, done=1 after 4 flush cycles.
//     Separately, with CONFIG_MEMORY_SIZE=48 and last word 0xFFFFFFFF -> bits [47:32]=0xFFFF, no out-of-range write.
//  5. Reset mid-FLUSH (cycle 2): rst_n low -> flush=0, config_memory=0, state IDLE asynchronously.
//  6. Abort + last handshake in the same cycle -> no commit, config_memory unchanged, flush=0.

Source files
------------

// File: rtl/lake_cfg_pkg.sv
// Shared types and helpers for the lakespec configuration sequencer.
package lake_cfg_pkg;

  typedef enum logic [1:0] {CFG_IDLE, CFG_LOAD, CFG_FLUSH, CFG_RUN} cfg_state_t;

  function automatic int num_words(input int size, input int w);
    return (size + w - 1) / w;
  endfunction

endpackage

// File: rtl/lake_flush_timer.sv
// Load/count-down timer that holds its active output high for FLUSH_CYCLES cycles after start.
module lake_flush_timer #(
  parameter int FLUSH_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  output logic active,
  output logic expire
);

  localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;
  logic             active_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg  <= '0;
      active_reg <= 1'b0;
    end else if (start) begin
      count_reg  <= CNT_W'(FLUSH_CYCLES);
      active_reg <= 1'b1;
    end else if (active_reg) begin
      if (count_reg == CNT_W'(1)) active_reg <= 1'b0;
      count_reg <= count_reg - CNT_W'(1);
    end
  end

  // Straight from the register so the flush line never glitches.
  assign active = active_reg;
  assign expire = active_reg && (count_reg == CNT_W'(1));

endmodule

// File: rtl/lake_config_sequencer.sv
// Streams narrow config words into a shadow register, commits them atomically to
// config_memory, then sequences the flush pulse that starts the lakespec schedule.
module lake_config_sequencer
  import lake_cfg_pkg::*;
#(
  parameter int  CONFIG_MEMORY_SIZE = 512,
  parameter int  WORD_W             = 32,
  parameter int  FLUSH_CYCLES       = 4,
  localparam int NUM_WORDS          = num_words(CONFIG_MEMORY_SIZE, WORD_W),
  localparam int CNT_W              = $clog2(NUM_WORDS + 1)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          cfg_start,
  input  logic                          cfg_abort,
  input  logic                          cfg_word_valid,
  output logic                          cfg_word_ready,
  input  logic [WORD_W-1:0]             cfg_word_data,
  output logic [CONFIG_MEMORY_SIZE-1:0] config_memory,
  output logic                          flush,
  output logic                          busy,
  output logic                          done,
  output logic [CNT_W-1:0]              word_count
);

  localparam int SHADOW_W = NUM_WORDS * WORD_W;

  cfg_state_t                    state_reg, state_next;
  logic [SHADOW_W-1:0]           shadow_reg, shadow_merged;
  logic [CONFIG_MEMORY_SIZE-1:0] config_reg;
  logic [CNT_W-1:0]              count_reg;
  logic handshake, last_word, commit, take_start, timer_expire;

  assign handshake  = cfg_word_valid && cfg_word_ready;
  assign last_word  = handshake && (count_reg == CNT_W'(NUM_WORDS - 1));
  assign commit     = last_word && !cfg_abort;
  assign take_start = cfg_start && (state_reg == CFG_IDLE || state_reg == CFG_RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= CFG_IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      CFG_IDLE:  if (take_start) state_next = CFG_LOAD;
      CFG_LOAD: begin
        if (cfg_abort)      state_next = CFG_IDLE;
        else if (last_word) state_next = CFG_FLUSH;
      end
      CFG_FLUSH: if (timer_expire) state_next = CFG_RUN;
      CFG_RUN:   if (take_start) state_next = CFG_LOAD;
      default:   state_next = CFG_IDLE;
    endcase
  end

  always_comb begin
    cfg_word_ready = (state_reg == CFG_LOAD);
    busy           = (state_reg == CFG_LOAD) || (state_reg == CFG_FLUSH);
    done           = (state_reg == CFG_RUN);
  end

  // The last word is merged combinationally so the commit needs no extra cycle.
  always_comb begin
    shadow_merged = shadow_reg;
    if (handshake) shadow_merged[int'(count_reg) * WORD_W +: WORD_W] = cfg_word_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_reg <= '0;
      count_reg  <= '0;
      config_reg <= '0;
    end else begin
      if (take_start) begin
        shadow_reg <= '0;
        count_reg  <= '0;
      end else if (handshake && !cfg_abort) begin
        shadow_reg <= shadow_merged;
        if (count_reg != CNT_W'(NUM_WORDS)) count_reg <= count_reg + CNT_W'(1);
      end
      if (commit) config_reg <= shadow_merged[CONFIG_MEMORY_SIZE-1:0];
    end
  end

  lake_flush_timer #(
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) u_flush_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (commit),
    .active (flush),
    .expire (timer_expire)
  );

  assign config_memory = config_reg;
  assign word_count    = count_reg;

endmodule
